// File: rtl/extint_controller_v2.sv
// External interrupt controller: synchronised IRQ inputs, edge/level pending, enable mask,
// fixed lowest-index priority, bus-mapped PEND/EN/MODE/CLAIM registers and core acknowledge.
module extint_controller_v2 #(
    parameter int SRC_NUM       = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int VA_WIDTH      = 4,
    parameter int BUS_WIDTH     = 32,
    parameter int BUS_ACC_WIDTH = 2,
    parameter int BUS_ACC_4B    = 2,
    localparam int ID_W         = $clog2(SRC_NUM + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ext_int_trigger,
    output logic [ID_W-1:0]          ext_int_id,
    input  logic                     ext_int_handled,
    input  logic [SRC_NUM-1:0]       ext_int_from,
    input  logic [VA_WIDTH-1:0]      addr,
    input  logic                     w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] acc,
    output logic [BUS_WIDTH-1:0]     rdata,
    input  logic [BUS_WIDTH-1:0]     wdata,
    input  logic                     req,
    output logic                     resp,
    output logic                     fault
);

    logic [SRC_NUM-1:0]   s;
    logic [SRC_NUM-1:0]   s_prev_q;
    logic [SRC_NUM-1:0]   rise;
    logic [SRC_NUM-1:0]   pend_q;
    logic [SRC_NUM-1:0]   pend_d;
    logic [SRC_NUM-1:0]   en_q;
    logic [SRC_NUM-1:0]   mode_q;
    logic [SRC_NUM-1:0]   insvc_q;
    logic [SRC_NUM-1:0]   insvc_d;
    logic [SRC_NUM-1:0]   act;
    logic [SRC_NUM-1:0]   win_oh;
    logic [SRC_NUM-1:0]   w1c_oh;
    logic [SRC_NUM-1:0]   claim_oh;
    logic [SRC_NUM-1:0]   ack_oh;
    logic [SRC_NUM-1:0]   clr;
    logic [SRC_NUM-1:0]   cmpl_oh;
    logic [ID_W-1:0]      win_id;
    logic [ID_W-1:0]      id_q;
    logic                 trig_q;
    logic                 resp_q;
    logic [BUS_WIDTH-1:0] rdata_q;
    logic [BUS_WIDTH-1:0] rdata_d;
    logic [31:0]          addr_ext;
    logic [1:0]           sel;
    logic                 valid;
    logic                 wr;
    logic                 rd;

    // Bus decode; a faulting request is simply never considered valid.
    assign addr_ext = 32'(addr);
    assign sel      = addr[3:2];
    assign fault    = req & ((acc != BUS_ACC_WIDTH'(BUS_ACC_4B)) |
                             (addr[1:0] != 2'b00) | (addr_ext > 32'd12));
    assign valid    = req & ~fault;
    assign wr       = valid & w_rb;
    assign rd       = valid & ~w_rb;

    assign act    = pend_q & en_q & ~insvc_q;
    assign win_oh = act & (~act + SRC_NUM'(1));

    always_comb begin
        win_id = '0;
        for (int i = SRC_NUM - 1; i >= 0; i--) begin
            if (act[i]) begin
                win_id = ID_W'(i + 1);
            end
        end
    end

    // Claim read and core ack both target the same winner, so OR-ing them clears it once.
    assign w1c_oh   = (wr && sel == 2'd0) ? wdata[SRC_NUM-1:0] : '0;
    assign claim_oh = (rd && sel == 2'd3) ? win_oh : '0;
    assign ack_oh   = ext_int_handled ? win_oh : '0;
    assign clr      = w1c_oh | claim_oh | ack_oh;

    generate
        for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_src
            logic [SYNC_STAGES-1:0] chain_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    chain_q <= '0;
                end else begin
                    chain_q <= {chain_q[SYNC_STAGES-2:0], ext_int_from[gi]};
                end
            end

            assign s[gi]       = chain_q[SYNC_STAGES-1];
            assign rise[gi]    = s[gi] & ~s_prev_q[gi];
            // Level sources track the line; edge sources let a new edge beat any clear.
            assign pend_d[gi]  = mode_q[gi] ? s[gi] : (rise[gi] | (pend_q[gi] & ~clr[gi]));
            assign cmpl_oh[gi] = wr && (sel == 2'd3) && (wdata == BUS_WIDTH'(gi + 1));
            assign insvc_d[gi] = (insvc_q[gi] | claim_oh[gi]) & ~cmpl_oh[gi];
        end
    endgenerate

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            case (sel)
                2'd0: rdata_d = BUS_WIDTH'(pend_q);
                2'd1: rdata_d = BUS_WIDTH'(en_q);
                2'd2: rdata_d = BUS_WIDTH'(mode_q);
                2'd3: rdata_d = BUS_WIDTH'(win_id);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev_q <= '0;
            pend_q   <= '0;
            en_q     <= '0;
            mode_q   <= '0;
            insvc_q  <= '0;
            trig_q   <= 1'b0;
            id_q     <= '0;
            rdata_q  <= '0;
            resp_q   <= 1'b0;
        end else begin
            s_prev_q <= s;
            pend_q   <= pend_d;
            insvc_q  <= insvc_d;
            if (wr && sel == 2'd1) begin
                en_q <= wdata[SRC_NUM-1:0];
            end
            if (wr && sel == 2'd2) begin
                mode_q <= wdata[SRC_NUM-1:0];
            end
            trig_q  <= |act;
            id_q    <= win_id;
            rdata_q <= rdata_d;
            resp_q  <= valid;
        end
    end

    assign ext_int_trigger = trig_q;
    assign ext_int_id      = id_q;
    assign rdata           = rdata_q;
    assign resp            = resp_q;

endmodule
